// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection and stall sequencer for a 5-stage MIPS pipeline.
// Drives PC / IF-ID / ID-EX enables from load-use, branch-in-ID and mul/div
// interlocks, sequences multi-cycle stalls with a small FSM and counts the
// stall cycles in a saturating counter.
// Optional build macro: HAZARD_R0_FILTER_EN (register $zero never matches).
module hazard_ctrl #(
   parameter int REG_W         = 5,
   parameter int LOAD_LAT      = 1,
   parameter int MULDIV_CYCLES = 8,
   parameter int CNT_W         = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_ex_mem_read,
   input  logic             i_ex_reg_write,
   input  logic [REG_W-1:0] i_ex_dest,
   input  logic             i_mem_mem_read,
   input  logic [REG_W-1:0] i_mem_dest,
   input  logic [REG_W-1:0] i_id_rs,
   input  logic [REG_W-1:0] i_id_rt,
   input  logic             i_id_uses_rs,
   input  logic             i_id_uses_rt,
   input  logic             i_id_branch,
   input  logic             i_id_muldiv,
   input  logic             i_id_hilo,
   input  logic             i_branch_taken,
   output logic             o_pc_write_en,
   output logic             o_ifid_write_en,
   output logic             o_idex_bubble,
   output logic             o_ifid_flush,
   output logic             o_muldiv_busy,
   output logic [CNT_W-1:0] o_stall_count
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_MULDIV = 2'd2
   } state_t;

   // Shared down-counter is wide enough for both LOAD_LAT-1 (<=6) and MULDIV_CYCLES-1 (<=62).
   localparam logic [5:0] LP_LOAD_INIT = 6'(LOAD_LAT - 1);
   localparam logic [5:0] LP_MD_INIT   = 6'(MULDIV_CYCLES - 1);
   localparam bit         LP_LOAD_SEQ  = (LOAD_LAT > 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [5:0]       r_cnt;
   logic [5:0]       w_cnt_next;
   logic [CNT_W-1:0] r_stall_count;

   logic w_match_ex;
   logic w_match_mem;
   logic w_load_haz;
   logic w_br_haz;
   logic w_md_haz;
   logic w_seq_haz;
   logic w_stall;

   // Source-register match against the EX and MEM destinations.
`ifdef HAZARD_R0_FILTER_EN
   assign w_match_ex  = (i_ex_dest != '0) &&
                        (((i_ex_dest == i_id_rs) && i_id_uses_rs) ||
                         ((i_ex_dest == i_id_rt) && i_id_uses_rt));
   assign w_match_mem = (i_mem_dest != '0) &&
                        (((i_mem_dest == i_id_rs) && i_id_uses_rs) ||
                         ((i_mem_dest == i_id_rt) && i_id_uses_rt));
`else
   assign w_match_ex  = ((i_ex_dest == i_id_rs) && i_id_uses_rs) ||
                        ((i_ex_dest == i_id_rt) && i_id_uses_rt);
   assign w_match_mem = ((i_mem_dest == i_id_rs) && i_id_uses_rs) ||
                        ((i_mem_dest == i_id_rt) && i_id_uses_rt);
`endif

   assign w_load_haz = i_ex_mem_read && w_match_ex;
   assign w_br_haz   = i_id_branch &&
                       ((i_ex_reg_write && w_match_ex) || (i_mem_mem_read && w_match_mem));
   assign w_md_haz   = (r_state == ST_MULDIV) && (i_id_muldiv || i_id_hilo);
   assign w_seq_haz  = (r_state == ST_LOAD);
   assign w_stall    = w_load_haz || w_br_haz || w_md_haz || w_seq_haz;

   // State and shared counter registers.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Next-state logic: load latency sequence takes precedence over a mul/div issue.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_load_haz && LP_LOAD_SEQ) begin
               w_state_next = ST_LOAD;
               w_cnt_next   = LP_LOAD_INIT;
            end else if (i_id_muldiv && !w_stall) begin
               w_state_next = ST_MULDIV;
               w_cnt_next   = LP_MD_INIT;
            end
         end
         ST_LOAD: begin
            if (r_cnt <= 6'd1) begin
               w_state_next = ST_IDLE;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt - 6'd1;
            end
         end
         ST_MULDIV: begin
            // A load hazard here only stalls combinationally; occupancy dominates.
            if (r_cnt == 6'd0) begin
               w_state_next = ST_IDLE;
            end else begin
               w_cnt_next = r_cnt - 6'd1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   // Pipeline enables: reset holds the pipe, stall beats a taken-branch flush.
   always_comb begin
      o_pc_write_en   = 1'b1;
      o_ifid_write_en = 1'b1;
      o_idex_bubble   = 1'b0;
      o_ifid_flush    = 1'b0;
      if (i_reset || w_stall) begin
         o_pc_write_en   = 1'b0;
         o_ifid_write_en = 1'b0;
         o_idex_bubble   = 1'b1;
      end else begin
         o_ifid_flush = i_branch_taken;
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_stall_count <= '0;
      end else if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
         r_stall_count <= r_stall_count + 1'b1;
      end
   end

   assign o_muldiv_busy = (r_state == ST_MULDIV);
   assign o_stall_count = r_stall_count;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard detection and stall sequencer for the 5-stage MIPS pipeline, sitting between ID-stage decode and the PC/IF-ID/ID-EX pipeline-register enables. It extends single-cycle load-use stalling with:
- configurable load-use latency;
- branch-in-ID operand hazards;
- a multi-cycle mul/div busy interlock;
- taken-branch IF/ID flush;
- a saturating stall-cycle counter.

Stalls are sequenced by an FSM so that multi-cycle stalls stay asserted after the producing instruction has left EX.

## Interface
Parameters:
- REG_W, 5, register address width
- LOAD_LAT, 1, load-use stall cycles (1..7)
- MULDIV_CYCLES, 8, mul/div busy cycles after issue (2..63)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- ex_mem_read  in  1  EX instruction is a load
- ex_reg_write  in  1  EX instruction writes a register
- ex_dest  in  REG_W  EX destination register
- mem_mem_read  in  1  MEM instruction is a load
- mem_dest  in  REG_W  MEM destination register
- id_rs, id_rt  in  REG_W  ID source registers
- id_uses_rs, id_uses_rt  in  1  ID actually reads rs / rt
- id_branch  in  1  ID is a branch compared in ID
- id_muldiv  in  1  ID is mult/div (issue request)
- id_hilo  in  1  ID reads HI/LO (mfhi/mflo)
- branch_taken  in  1  ID branch resolved taken
- pc_write_en  out  1  PC update enable
- ifid_write_en  out  1  IF/ID register enable
- idex_bubble  out  1  zero ID/EX control (insert NOP)
- ifid_flush  out  1  clear IF/ID on the next edge
- muldiv_busy  out  1  mul/div unit occupied
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- match(r) = r equals id_rs with id_uses_rs, or r equals id_rt with id_uses_rt.
- Stall sources, all combinational in the current cycle:
  - load_haz: ex_mem_read and match(ex_dest).
  - br_haz: id_branch and ((ex_reg_write and match(ex_dest)) or (mem_mem_read and match(mem_dest))).
  - md_haz: state MULDIV and (id_muldiv or id_hilo).
  - seq_haz: state LOAD.
- stall is the OR of all four sources.
- While stall is asserted: pc_write_en=0, ifid_write_en=0, idex_bubble=1, ifid_flush=0.
- Otherwise: pc_write_en=1, ifid_write_en=1, idex_bubble=0, ifid_flush=branch_taken.
- Stall has priority over flush: a taken branch that coincides with a stall is not flushed, because its operands are invalid.
- FSM states: IDLE, LOAD, MULDIV. A single down-counter cnt is shared by LOAD and MULDIV.
  - IDLE:
    - load_haz and LOAD_LAT>1: go to LOAD with cnt=LOAD_LAT-1.
    - Otherwise, id_muldiv and not stall: go to MULDIV with cnt=MULDIV_CYCLES-1.
  - LOAD:
    - cnt decrements each cycle.
    - When cnt=1, go to IDLE on the next edge.
    - id_muldiv issue is blocked while in LOAD.
  - MULDIV:
    - cnt decrements each cycle.
    - When cnt=0, go to IDLE.
    - A load_haz in this state stalls combinationally only; the FSM does not change state.
    - No second load-latency sequence is started while the mul/div is busy, because the mul/div occupancy dominates.
- muldiv_busy = (state == MULDIV).
- stall_count increments on every clock edge where stall=1 and saturates at all-ones.
- Reset values: state IDLE, cnt 0, stall_count 0, muldiv_busy 0. While reset is high: pc_write_en=0, ifid_write_en=0, idex_bubble=1, ifid_flush=0.

## Timing
- Load-use stall length is exactly LOAD_LAT cycles: the first cycle comes from load_haz, the remaining LOAD_LAT-1 from the LOAD state.
- br_haz stalls for as long as it holds, typically 1 cycle behind an ALU op and 2 cycles behind a load.
- Mul/div: the issue cycle is not a stall. muldiv_busy is high for MULDIV_CYCLES cycles starting on the next edge. A dependent id_hilo issues in the first cycle after muldiv_busy falls.
- Reset asserted mid-stall aborts the sequence immediately (asynchronous). The first cycle after deassertion behaves as IDLE.

## Configuration
- HAZARD_R0_FILTER_EN:
  - Defined: match(r) is forced to 0 when r==0, so writes to or reads of $zero never stall.
  - Undefined: register 0 is compared like any other register.

## Test plan
- Load-use, LOAD_LAT=1: ex_mem_read=1, ex_dest=5, id_rs=5, id_uses_rs=1 → one cycle of pc_write_en=0 and idex_bubble=1; then the FSM stays in IDLE and stall_count=1.
- Load-use, LOAD_LAT=3: same stimulus held for 1 cycle, then EX cleared → stall for exactly 3 cycles; stall_count=3.
- Branch behind load: id_branch=1, mem_mem_read=1, mem_dest=8, id_rt=8, id_uses_rt=1, branch_taken=1 → stall for the cycle, ifid_flush=0. On the next cycle with no hazard, ifid_flush=1.
- Mul/div, MULDIV_CYCLES=8: id_muldiv pulse → muldiv_busy high for 8 cycles. id_hilo=1 held → stall for 8 cycles, released in the cycle muldiv_busy=0.
- R0 filter: ex_mem_read=1, ex_dest=0, id_rs=0 → stall with the macro undefined, no stall with it defined. Separately, assert reset mid-LOAD → state IDLE and stall_count=0 immediately.
